// File: rtl/dc_mem_pkg.sv
// Shared definitions for the D-cache memory responder: line geometry,
// FSM state encoding and the latency counter width.
package dc_mem_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = 128;
    localparam int CNT_W      = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_WAIT = 3'd1;
    localparam state_t ST_WR_RESP = 3'd2;
    localparam state_t ST_RD_WAIT = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_RD_FIN  = 3'd5;

endpackage

// File: rtl/dc_mem_responder_if.sv
// D-cache refill/writeback bus between the LSU (master) and the memory
// responder (slave).
//   dcw_*          : masked 128-bit line write request, finish pulse back
//   dcr_*          : line read request
//   rqfull_1       : receiver backpressure for read data
//   rdat_m_*       : read line data and its one-cycle strobe
//   finish_mrd     : read-complete pulse
//   err_ovf        : sticky dropped-request flag
interface dc_mem_responder_if;
    import dc_mem_pkg::*;

    logic                  dcw_start_rq;
    logic [31:0]           dcw_in_addr;
    logic [LINE_BYTES-1:0] dcw_in_mask;
    logic [LINE_BITS-1:0]  dcw_in_data;
    logic                  dcw_finish_wresp;
    logic                  dcr_start_rq;
    logic [31:0]           dcr_rin_addr;
    logic                  rqfull_1;
    logic [LINE_BITS-1:0]  rdat_m_data;
    logic                  rdat_m_valid;
    logic                  finish_mrd;
    logic                  err_ovf;

    modport master (
        output dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
        output dcr_start_rq, dcr_rin_addr, rqfull_1,
        input  dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd, err_ovf
    );

    modport slave (
        input  dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
        input  dcr_start_rq, dcr_rin_addr, rqfull_1,
        output dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd, err_ovf
    );

endinterface

// File: rtl/dc_line_ram.sv
// Backing line store: 2^AWIDTH lines of 128 bits, byte-write enables,
// one write port and one registered read port.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we_i/waddr_i/wbe_i/wdata_i : write port
//   re_i/raddr_i/rdata_o       : read port, data valid the cycle after re_i
module dc_line_ram
    import dc_mem_pkg::*;
#(
    parameter int AWIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AWIDTH-1:0]     waddr_i,
    input  logic [LINE_BYTES-1:0] wbe_i,
    input  logic [LINE_BITS-1:0]  wdata_i,
    input  logic                  re_i,
    input  logic [AWIDTH-1:0]     raddr_i,
    output logic [LINE_BITS-1:0]  rdata_o
);

    logic [LINE_BITS-1:0] mem_q [2**AWIDTH];
    logic [LINE_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // The read register doubles as the visible read-data register, so it
    // holds its value between reads and clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dc_mem_responder.sv
// Memory-side responder for D-cache line refill/writeback. Captures write
// and read requests into one-deep pending slots, serves them one at a time
// from a line RAM with fixed latency (writes before reads), and returns a
// write-complete pulse or read data under receiver backpressure.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dc_mem_responder_if slave side
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | no job; start one when a slot or strobe is present
// WR_WAIT    | write latency countdown; RAM write on last cycle
// WR_RESP    | dcw_finish_wresp pulse; may start the next job
// RD_WAIT    | read latency countdown; RAM read on last cycle
// RD_DATA    | read data held; valid when receiver not full
// RD_FIN     | finish_mrd pulse; may start the next job
module dc_mem_responder
    import dc_mem_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int WR_LAT = 4,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dc_mem_responder_if.slave bus
);

    // Counter runs LAT-2 .. 0, giving LAT-1 wait cycles after the start cycle.
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 2);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 2);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 wr_vld_q, wr_vld_d;
    logic [AWIDTH-1:0]    wr_addr_q;
    logic [LINE_BYTES-1:0] wr_mask_q;
    logic [LINE_BITS-1:0] wr_data_q;
    logic                 rd_vld_q, rd_vld_d;
    logic [AWIDTH-1:0]    rd_addr_q;
    logic                 err_ovf_q;

    logic [AWIDTH-1:0]    job_addr_q;
    logic [LINE_BYTES-1:0] job_mask_q;
    logic [LINE_BITS-1:0] job_data_q;

    logic [AWIDTH-1:0]    dcw_line, dcr_line;
    logic                 can_start, start_wr, start_rd, cnt_done;
    logic                 wr_fill, wr_drop, rd_fill, rd_drop;
    logic                 wresp, rvalid, rfin, ram_we, ram_re;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 unused_addr_bits;

    assign dcw_line = bus.dcw_in_addr[AWIDTH+3:4];
    assign dcr_line = bus.dcr_rin_addr[AWIDTH+3:4];
    assign unused_addr_bits = ^{bus.dcw_in_addr[31:AWIDTH+4], bus.dcw_in_addr[3:0],
                                bus.dcr_rin_addr[31:AWIDTH+4], bus.dcr_rin_addr[3:0]};

    assign can_start = (state_q == ST_IDLE) || (state_q == ST_WR_RESP) || (state_q == ST_RD_FIN);
    assign start_wr  = can_start & (wr_vld_q | bus.dcw_start_rq);
    assign start_rd  = can_start & ~(wr_vld_q | bus.dcw_start_rq) & (rd_vld_q | bus.dcr_start_rq);
    assign cnt_done  = (cnt_q == '0);

    // A strobe fills its slot if the slot is empty and the strobe is not
    // bypassing straight into a job, or if the slot is being consumed now.
    assign wr_fill  = bus.dcw_start_rq & (wr_vld_q ? start_wr : ~start_wr);
    assign wr_drop  = bus.dcw_start_rq & wr_vld_q & ~start_wr;
    assign wr_vld_d = wr_fill | (wr_vld_q & ~start_wr);
    assign rd_fill  = bus.dcr_start_rq & (rd_vld_q ? start_rd : ~start_rd);
    assign rd_drop  = bus.dcr_start_rq & rd_vld_q & ~start_rd;
    assign rd_vld_d = rd_fill | (rd_vld_q & ~start_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WR_RESP, ST_RD_FIN: begin
                if (start_wr) begin
                    state_d = ST_WR_WAIT;
                    cnt_d   = WR_LOAD;
                end else if (start_rd) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = RD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_done) state_d = ST_WR_RESP;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RD_WAIT: begin
                if (cnt_done) state_d = ST_RD_DATA;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RD_DATA: begin
                if (!bus.rqfull_1) state_d = ST_RD_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM strobes are gated by rst_n so a job aborted by reset on its last
    // wait cycle leaves neither memory nor read data touched.
    always_comb begin
        wresp  = 1'b0;
        rvalid = 1'b0;
        rfin   = 1'b0;
        ram_we = 1'b0;
        ram_re = 1'b0;
        case (state_q)
            ST_WR_WAIT: ram_we = cnt_done & rst_n;
            ST_WR_RESP: wresp  = 1'b1;
            ST_RD_WAIT: ram_re = cnt_done & rst_n;
            ST_RD_DATA: rvalid = ~bus.rqfull_1;
            ST_RD_FIN:  rfin   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            wr_vld_q <= wr_vld_d;
            rd_vld_q <= rd_vld_d;
            if (wr_drop | rd_drop) err_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fill) begin
            wr_addr_q <= dcw_line;
            wr_mask_q <= bus.dcw_in_mask;
            wr_data_q <= bus.dcw_in_data;
        end
        if (rd_fill) rd_addr_q <= dcr_line;
        if (start_wr) begin
            job_addr_q <= wr_vld_q ? wr_addr_q : dcw_line;
            job_mask_q <= wr_vld_q ? wr_mask_q : bus.dcw_in_mask;
            job_data_q <= wr_vld_q ? wr_data_q : bus.dcw_in_data;
        end else if (start_rd) begin
            job_addr_q <= rd_vld_q ? rd_addr_q : dcr_line;
        end
    end

    dc_line_ram #(.AWIDTH(AWIDTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (job_addr_q),
        .wbe_i   (job_mask_q),
        .wdata_i (job_data_q),
        .re_i    (ram_re),
        .raddr_i (job_addr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.dcw_finish_wresp = wresp;
    assign bus.rdat_m_valid     = rvalid;
    assign bus.finish_mrd       = rfin;
    assign bus.rdat_m_data      = ram_rdata;
    assign bus.err_ovf          = err_ovf_q;

endmodule

// File: tb/tb_dc_mem_responder.sv
// Directed bench for dc_mem_responder with a timestamp-based job model that
// predicts every output on every cycle, plus literal checks per scenario.
module tb_dc_mem_responder;
    import dc_mem_pkg::*;

    localparam int AW     = 10;
    localparam int WR_LAT = 4;
    localparam int RD_LAT = 4;

    localparam logic [127:0] D1   = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] DAA  = {16{8'hAA}};
    localparam logic [127:0] DPRT = 128'h9999999999999999999999999999BBCC;
    localparam logic [127:0] DMIX = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAABBCC;
    localparam logic [127:0] D55  = {16{8'h55}};
    localparam logic [127:0] DBP  = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
    localparam logic [127:0] DA   = 128'h11111111222222223333333344444444;
    localparam logic [127:0] DB   = 128'h55556666777788889999AAAABBBBCCCC;
    localparam logic [127:0] DC   = 128'hFEDCBA9876543210FEDCBA9876543210;

    logic clk, rst_n;
    dc_mem_responder_if bus();

    dc_mem_responder #(.AWIDTH(AW), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wresp_cnt = 0, valid_cnt = 0, fin_cnt = 0;
    int wresp_cyc = -1, valid_cyc = -1, fin_cyc = -1;
    logic [127:0] valid_data;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [127:0] mem_m [int];
    bit           m_known = 0;
    bit           m_act, m_w, m_emit, m_err;
    int           m_t0, m_emit_c, m_line;
    logic [15:0]  m_mask;
    logic [127:0] m_data, m_last_rdat;
    bit           ws_v, rs_v;
    int           ws_line, rs_line;
    logic [15:0]  ws_mask;
    logic [127:0] ws_data;

    always @(negedge clk) begin
        bit free, e_wresp, e_valid, e_fin, st_w, st_r, wtaken, rtaken;
        logic [127:0] tmp;
        if (m_known) begin
            free    = !m_act || (m_w && cyc == m_t0 + WR_LAT) || (!m_w && m_emit && cyc == m_emit_c + 1);
            e_wresp = m_act && m_w && cyc == m_t0 + WR_LAT;
            e_valid = m_act && !m_w && !m_emit && cyc >= m_t0 + RD_LAT && !bus.rqfull_1;
            e_fin   = m_act && !m_w && m_emit && cyc == m_emit_c + 1;
            check("cyc_wresp", bus.dcw_finish_wresp, e_wresp);
            check("cyc_valid", bus.rdat_m_valid, e_valid);
            check("cyc_finish_mrd", bus.finish_mrd, e_fin);
            check("cyc_rdat", bus.rdat_m_data, m_last_rdat);
            check("cyc_err", bus.err_ovf, m_err);
        end
        if (bus.dcw_finish_wresp === 1'b1) begin wresp_cnt++; wresp_cyc = cyc; end
        if (bus.rdat_m_valid === 1'b1) begin valid_cnt++; valid_cyc = cyc; valid_data = bus.rdat_m_data; end
        if (bus.finish_mrd === 1'b1) begin fin_cnt++; fin_cyc = cyc; end

        if (!rst_n) begin
            m_known = 1; m_act = 0; m_emit = 0; m_err = 0;
            ws_v = 0; rs_v = 0; m_last_rdat = '0;
        end else if (m_known) begin
            if (m_act && m_w && cyc == m_t0 + WR_LAT - 1) begin
                tmp = mem_m.exists(m_line) ? mem_m[m_line] : '0;
                for (int b = 0; b < 16; b++)
                    if (m_mask[b]) tmp[8*b +: 8] = m_data[8*b +: 8];
                mem_m[m_line] = tmp;
            end
            if (m_act && !m_w && cyc == m_t0 + RD_LAT - 1)
                m_last_rdat = mem_m.exists(m_line) ? mem_m[m_line] : '0;
            if (e_valid) begin m_emit = 1; m_emit_c = cyc; end

            st_w = free && (ws_v || bus.dcw_start_rq);
            st_r = free && !st_w && (rs_v || bus.dcr_start_rq);
            wtaken = 0; rtaken = 0;
            if (st_w) begin
                m_act = 1; m_w = 1; m_t0 = cyc; m_emit = 0;
                if (ws_v) begin
                    m_line = ws_line; m_mask = ws_mask; m_data = ws_data; ws_v = 0;
                end else begin
                    m_line = int'(bus.dcw_in_addr[AW+3:4]); m_mask = bus.dcw_in_mask;
                    m_data = bus.dcw_in_data; wtaken = 1;
                end
            end else if (st_r) begin
                m_act = 1; m_w = 0; m_t0 = cyc; m_emit = 0;
                if (rs_v) begin m_line = rs_line; rs_v = 0; end
                else begin m_line = int'(bus.dcr_rin_addr[AW+3:4]); rtaken = 1; end
            end else if (free) begin
                m_act = 0;
            end
            if (bus.dcw_start_rq && !wtaken) begin
                if (ws_v) m_err = 1;
                else begin
                    ws_v = 1; ws_line = int'(bus.dcw_in_addr[AW+3:4]);
                    ws_mask = bus.dcw_in_mask; ws_data = bus.dcw_in_data;
                end
            end
            if (bus.dcr_start_rq && !rtaken) begin
                if (rs_v) m_err = 1;
                else begin rs_v = 1; rs_line = int'(bus.dcr_rin_addr[AW+3:4]); end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
        bus.dcw_start_rq = 1'b1; bus.dcw_in_addr = a; bus.dcw_in_mask = m; bus.dcw_in_data = d;
    endtask

    task automatic drive_rd(input logic [31:0] a);
        bus.dcr_start_rq = 1'b1; bus.dcr_rin_addr = a;
    endtask

    task automatic idle();
        bus.dcw_start_rq = 1'b0; bus.dcr_start_rq = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d, output int t0);
        drive_wr(a, m, d); t0 = cyc; step(1); idle(); step(5);
    endtask

    task automatic do_read(input logic [31:0] a, output int t0);
        drive_rd(a); t0 = cyc; step(1); idle(); step(6);
    endtask

    initial begin
        int t, w0, v0, f0;
        rst_n = 1'b0; bus.rqfull_1 = 1'b0;
        bus.dcw_in_addr = '0; bus.dcw_in_mask = '0; bus.dcw_in_data = '0; bus.dcr_rin_addr = '0;
        idle();
        step(3);
        rst_n = 1'b1;
        check("rst_wresp", bus.dcw_finish_wresp, 0);
        check("rst_valid", bus.rdat_m_valid, 0);
        check("rst_fin", bus.finish_mrd, 0);
        check("rst_rdat", bus.rdat_m_data, 0);
        check("rst_err", bus.err_ovf, 0);
        step(2);

        // write then read
        w0 = wresp_cnt;
        do_write(32'h0000_0120, 16'hFFFF, D1, t);
        check("wr1_resp_cycle", wresp_cyc, t + 4);
        check("wr1_resp_count", wresp_cnt, w0 + 1);
        v0 = valid_cnt; f0 = fin_cnt;
        do_read(32'h0000_0120, t);
        check("rd1_valid_cycle", valid_cyc, t + 4);
        check("rd1_data", valid_data, D1);
        check("rd1_fin_cycle", fin_cyc, t + 5);
        check("rd1_valid_count", valid_cnt, v0 + 1);
        check("rd1_fin_count", fin_cnt, f0 + 1);

        // partial mask
        do_write(32'h0000_0400, 16'hFFFF, DAA, t);
        do_write(32'h0000_0400, 16'h0003, DPRT, t);
        do_read(32'h0000_0400, t);
        check("partial_data", valid_data, DMIX);

        // simultaneous strobes, write first
        drive_wr(32'h0000_2000, 16'hFFFF, D55); drive_rd(32'h0000_2000);
        t = cyc; step(1); idle(); step(10);
        check("sim_wresp_cycle", wresp_cyc, t + 4);
        check("sim_valid_cycle", valid_cyc, t + 8);
        check("sim_fin_cycle", fin_cyc, t + 9);
        check("sim_data", valid_data, D55);
        check("sim_err", bus.err_ovf, 0);

        // backpressure
        do_write(32'h0000_0330, 16'hFFFF, DBP, t);
        v0 = valid_cnt; f0 = fin_cnt;
        bus.rqfull_1 = 1'b1; drive_rd(32'h0000_0330);
        t = cyc; step(1); idle(); step(13);
        check("bp_no_valid", valid_cnt, v0);
        check("bp_hold_data", bus.rdat_m_data, DBP);
        bus.rqfull_1 = 1'b0;
        step(3);
        check("bp_valid_cycle", valid_cyc, t + 14);
        check("bp_fin_cycle", fin_cyc, t + 15);
        check("bp_valid_count", valid_cnt, v0 + 1);
        check("bp_fin_count", fin_cnt, f0 + 1);

        // overflow: A bypasses, B waits in slot, C dropped
        w0 = wresp_cnt;
        drive_wr(32'h0000_0050, 16'hFFFF, DA); t = cyc; step(1);
        drive_wr(32'h0000_0060, 16'hFFFF, DB); step(1);
        drive_wr(32'h0000_0120, 16'hFFFF, DC); step(1);
        idle(); step(12);
        check("ovf_resp_count", wresp_cnt, w0 + 2);
        check("ovf_second_resp", wresp_cyc, t + 8);
        check("ovf_err", bus.err_ovf, 1);
        do_read(32'h0000_4120, t);
        check("ovf_dropped_alias", valid_data, D1);
        do_read(32'h0000_0060, t);
        check("ovf_kept_data", valid_data, DB);
        check("ovf_err_sticky", bus.err_ovf, 1);

        // reset during RD_WAIT
        v0 = valid_cnt; f0 = fin_cnt;
        drive_rd(32'h0000_0400); t = cyc; step(1); idle(); step(1);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        check("rstmid_wresp", bus.dcw_finish_wresp, 0);
        check("rstmid_valid", bus.rdat_m_valid, 0);
        check("rstmid_fin", bus.finish_mrd, 0);
        check("rstmid_rdat", bus.rdat_m_data, 0);
        check("rstmid_err", bus.err_ovf, 0);
        step(10);
        check("rstmid_no_valid", valid_cnt, v0);
        check("rstmid_no_fin", fin_cnt, f0);
        do_read(32'h0000_0400, t);
        check("rstmid_data_kept", valid_data, DMIX);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
